// File: rtl/sensors_intf_sample_writer_if.sv
// Avalon-MM write-only bus between the sample writer (master) and the sample memory s1 port (slave).
interface sensors_intf_sample_writer_if #(
  parameter int ADDR_W = 14
);
  logic [ADDR_W-1:0] avm_address;
  logic [3:0]        avm_byteenable;
  logic              avm_chipselect;
  logic              avm_write;
  logic [31:0]       avm_writedata;
  logic              avm_waitrequest;

  modport master (
    output avm_address, avm_byteenable, avm_chipselect, avm_write, avm_writedata,
    input  avm_waitrequest
  );

  modport slave (
    input  avm_address, avm_byteenable, avm_chipselect, avm_write, avm_writedata,
    output avm_waitrequest
  );
endinterface

// File: rtl/sensors_intf_sample_writer.sv
// Avalon-MM write master draining a valid/ready sample stream into a circular word buffer.
// Optional feature macro: SENSORS_INTF_SAMPLE_TIMESTAMP_EN (timestamp word written before each sample).
module sensors_intf_sample_writer #(
  parameter int ADDR_W     = 14,
  parameter int BASE_ADDR  = 0,
  parameter int DEPTH      = 10500,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [31:0]                  sample_data,
  input  logic                         sample_valid,
  output logic                         sample_ready,
  input  logic                         enable,
  input  logic                         clear,
  sensors_intf_sample_writer_if.master avm,
  output logic [ADDR_W-1:0]            wr_ptr,
  output logic [ADDR_W-1:0]            count,
  output logic                         wrapped,
  output logic                         dbg_state
);

  // Handshakes: a sample transfers on a rising clk edge with sample_valid & sample_ready high
  // (ready never depends on valid); a memory word transfers on an edge with avm_write high and
  // avm_waitrequest low, and address/data/write stay frozen while waitrequest is high.
  typedef enum logic {S_IDLE = 1'b0, S_WRITE = 1'b1} state_t;

`ifdef SENSORS_INTF_SAMPLE_TIMESTAMP_EN
  localparam int FW = 64;
`else
  localparam int FW = 32;
`endif
  localparam int                FA      = $clog2(FIFO_DEPTH);
  localparam logic [FA:0]       LVL_ONE = (FA+1)'(1);
  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] DEPTH_W = ADDR_W'(DEPTH);

  state_t            state;
  logic              clear_pending;
  logic [FW-1:0]     fifo_mem [FIFO_DEPTH];
  logic [FA:0]       fifo_wr, fifo_rd, fifo_level;
  logic              fifo_full, fifo_empty, push, next_avail, two_or_more;
  logic [FA-1:0]     rd_idx, rd_idx_nxt;
  logic [FW-1:0]     push_word, head_word, next_word;
  logic [31:0]       head_first, next_first;
  logic [ADDR_W-1:0] ptr_nxt;

  assign fifo_level  = fifo_wr - fifo_rd;
  assign fifo_full   = fifo_level[FA];
  assign fifo_empty  = (fifo_level == '0);
  // A clear seen mid-write keeps the input closed until the flush lands, so nothing is lost to it.
  assign sample_ready = ~reset & ~fifo_full & ~clear & ~clear_pending;
  assign push        = sample_valid & sample_ready;
  assign rd_idx      = fifo_rd[FA-1:0];
  assign rd_idx_nxt  = rd_idx + 1'b1;
  assign head_word   = fifo_mem[rd_idx];
  assign two_or_more = (fifo_level > LVL_ONE);
  assign next_avail  = two_or_more | push;
  assign next_word   = two_or_more ? fifo_mem[rd_idx_nxt] : push_word;
  assign ptr_nxt     = (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
  assign dbg_state   = state;

`ifdef SENSORS_INTF_SAMPLE_TIMESTAMP_EN
  logic [31:0] ts_cnt;
  logic        word_sel;  // 0: timestamp word of the pair is on the bus, 1: data word

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ts_cnt <= '0;
    else       ts_cnt <= ts_cnt + 1'b1;
  end

  assign push_word  = {ts_cnt, sample_data};
  assign head_first = head_word[63:32];
  assign next_first = next_word[63:32];
`else
  assign push_word  = sample_data;
  assign head_first = head_word;
  assign next_first = next_word;
`endif

  always_ff @(posedge clk) begin
    if (push) fifo_mem[fifo_wr[FA-1:0]] <= push_word;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= S_IDLE;
      clear_pending      <= 1'b0;
      fifo_wr            <= '0;
      fifo_rd            <= '0;
      wr_ptr             <= '0;
      count              <= '0;
      wrapped            <= 1'b0;
      avm.avm_address    <= '0;
      avm.avm_byteenable <= '0;
      avm.avm_chipselect <= 1'b0;
      avm.avm_write      <= 1'b0;
      avm.avm_writedata  <= '0;
`ifdef SENSORS_INTF_SAMPLE_TIMESTAMP_EN
      word_sel           <= 1'b0;
`endif
    end else begin
      if (push) fifo_wr <= fifo_wr + 1'b1;
      case (state)
        S_IDLE: begin
          if (clear) begin
            fifo_wr <= '0;
            fifo_rd <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            wrapped <= 1'b0;
          end else if (enable && !fifo_empty) begin
            avm.avm_address    <= BASE + wr_ptr;
            avm.avm_writedata  <= head_first;
            avm.avm_write      <= 1'b1;
            avm.avm_chipselect <= 1'b1;
            avm.avm_byteenable <= 4'hF;
`ifdef SENSORS_INTF_SAMPLE_TIMESTAMP_EN
            word_sel           <= 1'b0;
`endif
            state              <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (clear) clear_pending <= 1'b1;
          if (!avm.avm_waitrequest) begin
            if (clear || clear_pending) begin
              // The word just landed in memory, but its pointer update is dropped by the flush.
              fifo_wr            <= '0;
              fifo_rd            <= '0;
              wr_ptr             <= '0;
              count              <= '0;
              wrapped            <= 1'b0;
              clear_pending      <= 1'b0;
              avm.avm_write      <= 1'b0;
              avm.avm_chipselect <= 1'b0;
              avm.avm_byteenable <= 4'h0;
              state              <= S_IDLE;
            end else begin
              wr_ptr          <= ptr_nxt;
              avm.avm_address <= BASE + ptr_nxt;
              if (wr_ptr == LAST) wrapped <= 1'b1;
              if (count != DEPTH_W) count <= count + 1'b1;
`ifdef SENSORS_INTF_SAMPLE_TIMESTAMP_EN
              if (!word_sel) begin
                avm.avm_writedata <= head_word[31:0];
                word_sel          <= 1'b1;
              end else
`endif
              begin
                fifo_rd <= fifo_rd + 1'b1;
                if (enable && next_avail) begin
                  avm.avm_writedata <= next_first;
`ifdef SENSORS_INTF_SAMPLE_TIMESTAMP_EN
                  word_sel          <= 1'b0;
`endif
                end else begin
                  avm.avm_write      <= 1'b0;
                  avm.avm_chipselect <= 1'b0;
                  avm.avm_byteenable <= 4'h0;
                  state              <= S_IDLE;
                end
              end
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sensors_intf_sample_writer.sv
// Self-checking bench for sensors_intf_sample_writer: directed stimulus, expected-write queue.
module tb_sensors_intf_sample_writer;
  localparam int ADDR_W     = 14;
  localparam int BASE_ADDR  = 0;
  localparam int DEPTH      = 8;
  localparam int FIFO_DEPTH = 4;
`ifdef SENSORS_INTF_SAMPLE_TIMESTAMP_EN
  localparam int WPS = 2;
`else
  localparam int WPS = 1;
`endif
  localparam int EW = 1 + ADDR_W + 32;  // {wrapped before this word, address, data}

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [31:0]       sample_data = '0;
  logic              sample_valid = 1'b0;
  logic              sample_ready;
  logic              enable = 1'b0;
  logic              clear = 1'b0;
  logic [ADDR_W-1:0] wr_ptr, count;
  logic              wrapped, dbg_state;

  sensors_intf_sample_writer_if #(.ADDR_W(ADDR_W)) bus ();

  sensors_intf_sample_writer #(
    .ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR), .DEPTH(DEPTH), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .sample_data(sample_data), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .enable(enable), .clear(clear), .avm(bus),
    .wr_ptr(wr_ptr), .count(count), .wrapped(wrapped), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int          cyc = 0;
  logic [31:0] tb_ts;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk or posedge reset) begin
    if (reset) tb_ts <= '0;
    else       tb_ts <= tb_ts + 1;
  end

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int            wr_cyc[$];
  int            n_checks = 0, n_fail = 0, n_writes = 0;
  int            model_ptr = 0, model_count = 0;
  logic          model_wrapped = 1'b0;
  int            last_acc_cyc = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_word(input logic [31:0] d);
    exp_q.push_back({model_wrapped, ADDR_W'(BASE_ADDR + model_ptr), d});
    if (model_ptr == DEPTH - 1) begin
      model_ptr     = 0;
      model_wrapped = 1'b1;
    end else begin
      model_ptr++;
    end
    if (model_count < DEPTH) model_count++;
  endtask

  task automatic model_clear();
    model_ptr     = 0;
    model_count   = 0;
    model_wrapped = 1'b0;
  endtask

  // Completed memory transfers are compared against the head of the expected queue.
  always @(negedge clk) begin
    if (!reset && bus.avm_write && !bus.avm_waitrequest) begin
      logic [EW-1:0] e;
      n_writes++;
      wr_cyc.push_back(cyc);
      check_eq("write_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_eq("wr_addr", 64'(bus.avm_address), 64'(e[EW-2:32]));
        check_eq("wr_data", 64'(bus.avm_writedata), 64'(e[31:0]));
        check_eq("wr_byteen", 64'(bus.avm_byteenable), 64'hF);
        check_eq("wr_chipsel", 64'(bus.avm_chipselect), 64'd1);
        check_eq("wrapped_at_write", 64'(wrapped), 64'(e[EW-1]));
        check_eq("ptr_at_write", 64'(wr_ptr), 64'(ADDR_W'(e[EW-2:32] - ADDR_W'(BASE_ADDR))));
      end
    end
  end

  // ---------------- driver tasks (all start and end at posedge+1) ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input bit chk);
    reset = 1'b1; sample_valid = 1'b0; clear = 1'b0; bus.avm_waitrequest = 1'b0;
    repeat (2) @(negedge clk);
    if (chk) begin
      check_eq("rst_ready", 64'(sample_ready), 64'd0);
      check_eq("rst_write", 64'(bus.avm_write), 64'd0);
      check_eq("rst_chipsel", 64'(bus.avm_chipselect), 64'd0);
      check_eq("rst_byteen", 64'(bus.avm_byteenable), 64'd0);
      check_eq("rst_addr", 64'(bus.avm_address), 64'd0);
      check_eq("rst_wdata", 64'(bus.avm_writedata), 64'd0);
      check_eq("rst_wr_ptr", 64'(wr_ptr), 64'd0);
      check_eq("rst_count", 64'(count), 64'd0);
      check_eq("rst_wrapped", 64'(wrapped), 64'd0);
      check_eq("rst_state", 64'(dbg_state), 64'd0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    model_clear();
    @(negedge clk);
    if (chk) check_eq("post_rst_ready", 64'(sample_ready), 64'd1);
    tick(1);
  endtask

  task automatic push_sample(input logic [31:0] d);
    bit ok = 1'b0;
    sample_data  = d;
    sample_valid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (sample_ready) begin
        ok = 1'b1;
        last_acc_cyc = cyc;
`ifdef SENSORS_INTF_SAMPLE_TIMESTAMP_EN
        model_word(tb_ts);
`endif
        model_word(d);
      end
      @(posedge clk); #1;
    end
    sample_valid = 1'b0;
    check_eq("push_accept", 64'(ok), 64'd1);
  endtask

  task automatic wait_drain(input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0 && !bus.avm_write) done = 1'b1;
    end
    check_eq({tag, "_drain"}, 64'(done), 64'd1);
    tick(1);
  endtask

  task automatic wait_write_seen(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.avm_write) seen = 1'b1;
    end
    check_eq({tag, "_write_seen"}, 64'(seen), 64'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int w0, acc;
    logic [EW-1:0] held;
    bus.avm_waitrequest = 1'b0;
    apply_reset(1'b1);

    // Back-to-back writes at 1 word/clk.
    enable = 1'b1; wr_cyc.delete(); w0 = n_writes;
    push_sample(32'hA1); acc = last_acc_cyc;
    push_sample(32'hA2);
    push_sample(32'hA3);
    wait_drain("t1");
    check_eq("t1_writes", 64'(n_writes - w0), 64'(3 * WPS));
    check_eq("t1_latency", 64'(wr_cyc[0] - acc), 64'd2);
    for (int i = 1; i < wr_cyc.size(); i++)
      check_eq("t1_back_to_back", 64'(wr_cyc[i] - wr_cyc[i-1]), 64'd1);
    check_eq("t1_wr_ptr", 64'(wr_ptr), 64'(3 * WPS));
    check_eq("t1_count", 64'(count), 64'(3 * WPS));

    // Waitrequest stall holds the bus for 4 cycles.
    apply_reset(1'b0);
    enable = 1'b1; bus.avm_waitrequest = 1'b1; w0 = n_writes;
    push_sample(32'h55);
    wait_write_seen("t2");
    held = exp_q[0];
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      check_eq("t2_hold_write", 64'(bus.avm_write), 64'd1);
      check_eq("t2_hold_addr", 64'(bus.avm_address), 64'(held[EW-2:32]));
      check_eq("t2_hold_data", 64'(bus.avm_writedata), 64'(held[31:0]));
      @(posedge clk); #1;
    end
    bus.avm_waitrequest = 1'b0;
    wait_drain("t2");
    check_eq("t2_writes", 64'(n_writes - w0), 64'(WPS));
    check_eq("t2_wr_ptr", 64'(wr_ptr), 64'(WPS));

    // Disabled writes: FIFO fills and backpressures, then drains.
    apply_reset(1'b0);
    enable = 1'b0; w0 = n_writes;
    for (int i = 0; i < 4; i++) push_sample(32'h300 + i);
    sample_data = 32'h304; sample_valid = 1'b1;
    @(negedge clk);
    check_eq("t3_ready_full", 64'(sample_ready), 64'd0);
    tick(5);
    check_eq("t3_no_writes", 64'(n_writes - w0), 64'd0);
    enable = 1'b1;
    push_sample(32'h304);
    wait_drain("t3");
    check_eq("t3_writes", 64'(n_writes - w0), 64'(5 * WPS));
    check_eq("t3_count", 64'(count), 64'(model_count));
    check_eq("t3_wr_ptr", 64'(wr_ptr), 64'(model_ptr));

    // Wrap of the circular buffer.
    apply_reset(1'b0);
    enable = 1'b1; w0 = n_writes;
    for (int i = 0; i < 10; i++) push_sample(32'h400 + i);
    wait_drain("t4");
    check_eq("t4_writes", 64'(n_writes - w0), 64'(10 * WPS));
    check_eq("t4_count", 64'(count), 64'(DEPTH));
    check_eq("t4_wr_ptr", 64'(wr_ptr), 64'(model_ptr));
    check_eq("t4_wrapped", 64'(wrapped), 64'd1);

    // Clear during a stalled write: write completes, then flush.
    apply_reset(1'b0);
    enable = 1'b1;
    for (int i = 0; i < 5; i++) push_sample(32'h500 + i);
    wait_drain("t5a");
    bus.avm_waitrequest = 1'b1; w0 = n_writes;
    push_sample(32'h5A);
    push_sample(32'h5B);
    wait_write_seen("t5");
    @(posedge clk); #1;
    clear = 1'b1;
    @(negedge clk);
    check_eq("t5_ready_clear", 64'(sample_ready), 64'd0);
    @(posedge clk); #1;
    clear = 1'b0;
    while (exp_q.size() > 1) void'(exp_q.pop_back());
    model_clear();
    tick(1);
    bus.avm_waitrequest = 1'b0;
    wait_drain("t5b");
    check_eq("t5_writes", 64'(n_writes - w0), 64'd1);
    check_eq("t5_wr_ptr", 64'(wr_ptr), 64'd0);
    check_eq("t5_count", 64'(count), 64'd0);
    check_eq("t5_wrapped", 64'(wrapped), 64'd0);
    push_sample(32'h5C);
    wait_drain("t5c");
    check_eq("t5_after_wr_ptr", 64'(wr_ptr), 64'(WPS));

`ifdef SENSORS_INTF_SAMPLE_TIMESTAMP_EN
    // Timestamp captured at acceptance, written ahead of the data word.
    apply_reset(1'b0);
    enable = 1'b1;
    for (int i = 0; i < 200 && tb_ts != 32'd100; i++) tick(1);
    push_sample(32'hBEEF);
    wait_drain("t6");
    check_eq("t6_wr_ptr", 64'(wr_ptr), 64'd2);
`endif

    // Reset in the middle of a stalled transfer drops avm_write at once.
    apply_reset(1'b0);
    enable = 1'b1; bus.avm_waitrequest = 1'b1;
    push_sample(32'h77);
    wait_write_seen("t7");
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check_eq("t7_async_write", 64'(bus.avm_write), 64'd0);
    check_eq("t7_async_chipsel", 64'(bus.avm_chipselect), 64'd0);
    apply_reset(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
